// File: rtl/rom_leitor_pkg.sv
// Shared widths, end-marker value and FSM state type for the ROM reader.
package rom_leitor_pkg;

  localparam int LARG_END  = 9;
  localparam int LARG_DADO = 8;
  localparam logic [7:0] MARCADOR = 8'hFF;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    LENDO  = 2'd1,
    FINAL  = 2'd2
  } estado_t;

endpackage

// File: rtl/rom_leitor_fifo.sv
// Small synchronous FIFO for the reader's output stream; head is visible combinationally.
module rom_leitor_fifo #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARGURA      = rom_leitor_pkg::LARG_DADO
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_push,
  input  logic [LARGURA-1:0]              i_dado,
  input  logic                            i_pop,
  output logic [LARGURA-1:0]              o_dado,
  output logic [$clog2(PROFUNDIDADE):0]   o_contagem,
  output logic                            o_vazio,
  output logic                            o_cheio
);

  localparam int LP = $clog2(PROFUNDIDADE);

  logic [LARGURA-1:0] r_mem [PROFUNDIDADE];
  logic [LP-1:0]      r_ptr_esc;
  logic [LP-1:0]      r_ptr_lei;
  logic [LP:0]        r_contagem;
  logic               w_push;
  logic               w_pop;

  assign o_vazio    = (r_contagem == '0);
  assign o_cheio    = (r_contagem == (LP+1)'(PROFUNDIDADE));
  assign o_contagem = r_contagem;
  assign o_dado     = r_mem[r_ptr_lei];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_vazio;
  assign w_push = i_push & (~o_cheio | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROFUNDIDADE; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_ptr_esc] <= i_dado;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr_esc  <= '0;
      r_ptr_lei  <= '0;
      r_contagem <= '0;
    end else begin
      if (w_push) r_ptr_esc <= r_ptr_esc + 1'b1;
      if (w_pop)  r_ptr_lei <= r_ptr_lei + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_contagem <= r_contagem + 1'b1;
        2'b01:   r_contagem <= r_contagem - 1'b1;
        default: r_contagem <= r_contagem;
      endcase
    end
  end

endmodule

// File: rtl/rom_leitor.sv
// Reads a byte range from a 512x8 registered-read ROM and streams it out on valid/ready.
// Define MARCADOR_FIM_EN to make an 8'hFF byte from the ROM terminate the transfer.
module rom_leitor #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARG_END     = rom_leitor_pkg::LARG_END,
  parameter int LARG_DADO    = rom_leitor_pkg::LARG_DADO
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 Iniciar,
  input  logic [LARG_END-1:0]  EnderecoInicial,
  input  logic [LARG_END:0]    Quantidade,
  output logic [LARG_END-1:0]  Endereco,
  input  logic [LARG_DADO-1:0] Dados,
  output logic [LARG_DADO-1:0] Saida,
  output logic                 Valido,
  input  logic                 Pronto,
  output logic                 Ocupado,
  output logic                 Fim
);

  import rom_leitor_pkg::*;

  localparam int LP = $clog2(PROFUNDIDADE);

  estado_t              r_estado;
  estado_t              w_estado_next;
  logic [LARG_END-1:0]  r_addr_ptr;
  logic [LARG_END-1:0]  r_endereco;
  logic [LARG_END:0]    r_rest_ler;
  logic [LARG_END:0]    r_rest_emitir;
  logic [1:0]           r_v_pipe;
  logic                 r_parar;

  logic [LARG_DADO-1:0] w_fifo_saida;
  logic [LP:0]          w_fifo_contagem;
  logic                 w_fifo_vazio;
  logic                 w_fifo_cheio;
  logic [1:0]           w_em_voo;
  logic [LP+1:0]        w_ocupacao;
  logic                 w_aceita;
  logic                 w_emitir;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_marcador;
  logic                 w_ultimo;
  logic                 w_esvazia;

  // r_v_pipe[0]: address issued this cycle; r_v_pipe[1]: its byte is now on Dados.
  assign w_em_voo   = {1'b0, r_v_pipe[0]} + {1'b0, r_v_pipe[1]};
  assign w_ocupacao = (LP+2)'(w_fifo_contagem) + (LP+2)'(w_em_voo);
  assign w_pop      = ~w_fifo_vazio & Pronto;

`ifdef MARCADOR_FIM_EN
  assign w_marcador = r_v_pipe[1] & (Dados == LARG_DADO'(MARCADOR));
`else
  assign w_marcador = 1'b0;
`endif

  assign w_push   = r_v_pipe[1] & ~w_marcador;
  assign w_aceita = (r_estado == OCIOSO) & Iniciar;
  assign w_emitir = (r_estado == LENDO) & (r_rest_ler != '0) & ~w_fifo_cheio & ~w_marcador
                  & (w_ocupacao < (LP+2)'(PROFUNDIDADE));

  // Finish on the edge where the last byte leaves, so Fim follows it directly.
  assign w_ultimo  = (r_rest_emitir == (LARG_END+1)'(w_pop));
  assign w_esvazia = (w_fifo_contagem == '0)
                   | ((w_fifo_contagem == (LP+1)'(1)) & w_pop);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_estado <= OCIOSO;
    else        r_estado <= w_estado_next;
  end

  always_comb begin
    w_estado_next = r_estado;
    unique case (r_estado)
      OCIOSO: if (Iniciar) w_estado_next = (Quantidade == '0) ? FINAL : LENDO;
      LENDO:  if (w_ultimo | ((r_parar | w_marcador) & w_esvazia)) w_estado_next = FINAL;
      FINAL:  w_estado_next = OCIOSO;
      default: w_estado_next = OCIOSO;
    endcase
  end

  always_comb begin
    Ocupado = (r_estado == LENDO);
    Fim     = (r_estado == FINAL);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_addr_ptr    <= '0;
      r_endereco    <= '0;
      r_rest_ler    <= '0;
      r_rest_emitir <= '0;
      r_v_pipe      <= '0;
      r_parar       <= 1'b0;
    end else begin
      if (w_aceita) begin
        r_addr_ptr    <= EnderecoInicial;
        r_rest_ler    <= Quantidade;
        r_rest_emitir <= Quantidade;
        r_parar       <= 1'b0;
      end
      if (w_emitir) begin
        r_endereco <= r_addr_ptr;
        r_addr_ptr <= r_addr_ptr + 1'b1;
        r_rest_ler <= r_rest_ler - 1'b1;
      end
      if (w_pop) r_rest_emitir <= r_rest_emitir - 1'b1;
      // The marker drops itself and everything issued after it.
      if (w_marcador) begin
        r_rest_ler <= '0;
        r_parar    <= 1'b1;
        r_v_pipe   <= 2'b00;
      end else begin
        r_v_pipe   <= {r_v_pipe[0], w_emitir};
      end
    end
  end

  rom_leitor_fifo #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (LARG_DADO)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RST_n),
    .i_push     (w_push),
    .i_dado     (Dados),
    .i_pop      (w_pop),
    .o_dado     (w_fifo_saida),
    .o_contagem (w_fifo_contagem),
    .o_vazio    (w_fifo_vazio),
    .o_cheio    (w_fifo_cheio)
  );

  assign Endereco = r_endereco;
  assign Saida    = w_fifo_saida;
  assign Valido   = ~w_fifo_vazio;

endmodule

// File: tb/tb_rom_leitor.sv
// Scoreboard bench for rom_leitor: a ROM model feeds the DUT, expected bytes come from a range model.
module tb_rom_leitor;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       Iniciar = 1'b0;
  logic [8:0] EnderecoInicial = '0;
  logic [9:0] Quantidade = '0;
  logic [8:0] Endereco;
  logic [7:0] Dados;
  logic [7:0] Saida;
  logic       Valido;
  logic       Pronto = 1'b0;
  logic       Ocupado;
  logic       Fim;

  int checks = 0;
  int errors = 0;
  int n_transf = 0;
  logic [7:0] rom [512];
  logic [7:0] exp_q [$];

  localparam int LIMITE = 4000;

  rom_leitor dut (
    .CLK             (CLK),
    .RST_n           (RST_n),
    .Iniciar         (Iniciar),
    .EnderecoInicial (EnderecoInicial),
    .Quantidade      (Quantidade),
    .Endereco        (Endereco),
    .Dados           (Dados),
    .Saida           (Saida),
    .Valido          (Valido),
    .Pronto          (Pronto),
    .Ocupado         (Ocupado),
    .Fim             (Fim)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: one-cycle registered read.
  always @(posedge CLK) Dados <= rom[Endereco];

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  // Expected stream: the bytes of the requested range, cut at the first marker when enabled.
  task automatic modelo(input int ini, input int qtd);
    logic [7:0] b;
    for (int i = 0; i < qtd; i++) begin
      b = rom[9'((ini + i) % 512)];
`ifdef MARCADOR_FIM_EN
      if (b == 8'hFF) break;
`endif
      exp_q.push_back(b);
    end
  endtask

  // Monitor: pops on every transfer and checks hold behaviour under backpressure.
  initial begin
    logic       hold;
    logic [7:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      if (!RST_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valido", 32'(Valido), 32'd1);
          chk("hold_saida", 32'(Saida), 32'(held));
        end
        if (Valido && Pronto) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0d expected no byte", Saida);
          end else begin
            chk("byte", 32'(Saida), 32'(exp_q.pop_front()));
          end
          n_transf++;
          $display("transfer %0d: Saida=%0d", n_transf, Saida);
        end
        hold = Valido && !Pronto;
        held = Saida;
      end
    end
  end

  // modo: 0 always ready, 1 toggling, 2 random.
  task automatic run(input int ini, input int qtd, input int modo, input bit tempo, input bit pulso);
    int c;
    int fim_c;
    int n_exp;
    modelo(ini, qtd);
    n_exp = exp_q.size();
    @(posedge CLK); #1;
    EnderecoInicial = 9'(ini);
    Quantidade      = 10'(qtd);
    Iniciar         = 1'b1;
    Pronto          = 1'b1;
    @(posedge CLK); #1;
    Iniciar         = 1'b0;
    EnderecoInicial = 9'($urandom);
    Quantidade      = 10'($urandom_range(1, 512));
    c = 0;
    fim_c = -1;
    while (c <= LIMITE) begin
      if (c == 0 && qtd > 0) chk("ocupado_inicio", 32'(Ocupado), 32'd1);
      if (n_exp == 0) chk("valido_sem_dados", 32'(Valido), 32'd0);
      if (tempo && c == 2 && n_exp > 0) chk("latencia_antes", 32'(Valido), 32'd0);
      if (tempo && c >= 3 && c < 3 + n_exp) chk("valido_continuo", 32'(Valido), 32'd1);
      if (tempo && c >= 1 && c <= 4 && c <= qtd)
        chk("endereco", 32'(Endereco), 32'((ini + c - 1) % 512));
      if (Fim) begin
        fim_c = c;
        break;
      end
      if (pulso && c == 4) begin
        Iniciar = 1'b1;
        EnderecoInicial = 9'd100;
        Quantidade = 10'd3;
      end
      if (pulso && c == 5) Iniciar = 1'b0;
      case (modo)
        0:       Pronto = 1'b1;
        1:       Pronto = c[0];
        default: Pronto = 1'($urandom_range(0, 1));
      endcase
      @(posedge CLK); #1;
      c++;
    end
    Iniciar = 1'b0;
    if (fim_c < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_fim: got no Fim expected Fim within %0d cycles", LIMITE);
      exp_q.delete();
    end else begin
      chk("fim_bytes_pendentes", 32'(exp_q.size()), 32'd0);
      chk("fim_ocupado", 32'(Ocupado), 32'd0);
      if (tempo && qtd == 0) chk("fim_qtd0_rapido", 32'(fim_c <= 2), 32'd1);
      if (tempo && qtd > 0 && n_exp == qtd) chk("fim_ciclo", 32'(fim_c), 32'(3 + qtd));
      @(posedge CLK); #1;
      chk("fim_pulso_unico", 32'(Fim), 32'd0);
      chk("ocioso_valido", 32'(Valido), 32'd0);
    end
    $display("run ini=%0d qtd=%0d modo=%0d: expected %0d bytes, Fim at cycle %0d", ini, qtd, modo, n_exp, fim_c);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before 900000");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 512; i++) rom[i] = 8'hFF;
    rom[0] = 8'd50; rom[1] = 8'd43; rom[2] = 8'd33; rom[3] = 8'd25;
    rom[4] = 8'd15; rom[5] = 8'd50; rom[6] = 8'd255; rom[7] = 8'd50;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_endereco", 32'(Endereco), 32'd0);
    chk("reset_valido", 32'(Valido), 32'd0);
    chk("reset_saida", 32'(Saida), 32'd0);
    chk("reset_ocupado", 32'(Ocupado), 32'd0);
    chk("reset_fim", 32'(Fim), 32'd0);
    RST_n = 1'b1;
    repeat (2) @(posedge CLK);

    run(0, 5, 0, 1'b1, 1'b0);
    run(0, 8, 1, 1'b0, 1'b0);
    run(510, 4, 0, 1'b1, 1'b0);
    run(0, 0, 0, 1'b1, 1'b0);
    run(0, 8, 0, 1'b0, 1'b1);

    // Reset in the middle of a transfer, after three bytes have gone out.
    base = n_transf;
    modelo(0, 8);
    @(posedge CLK); #1;
    EnderecoInicial = 9'd0;
    Quantidade = 10'd8;
    Iniciar = 1'b1;
    Pronto = 1'b1;
    @(posedge CLK); #1;
    Iniciar = 1'b0;
    for (int k = 0; k < 50 && n_transf < base + 3; k++) @(posedge CLK);
    chk("reset_meio_progresso", 32'(n_transf - base), 32'd3);
    #3;
    RST_n = 1'b0;
    #1;
    chk("reset_meio_valido", 32'(Valido), 32'd0);
    chk("reset_meio_ocupado", 32'(Ocupado), 32'd0);
    chk("reset_meio_endereco", 32'(Endereco), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST_n = 1'b1;
    run(3, 4, 0, 1'b1, 1'b0);

    for (int k = 0; k < 6; k++)
      run(int'($urandom_range(0, 511)), int'($urandom_range(0, 20)), 2, 1'b0, 1'b0);
    run(int'($urandom_range(0, 511)), 512, 2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
